// File: rtl/ps_node_regs.sv
// ps_node_regs: node-side responder on the PS configuration network.
// Accepts single-beat read/write requests addressed to NODE_ID, holds a bank
// of RW configuration registers plus read-only STATUS and ID words, and
// returns exactly one response beat per accepted request.
module ps_node_regs #(
  parameter int NODE_ID         = 0,
  parameter int NODE_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGS        = 8,
  parameter int ADDR_WIDTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [NODE_ADDR_WIDTH-1:0]     node_addr,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           wen,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           wresp,
  output logic                           wready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_out,
  output logic [NUM_REGS-1:0]            cfg_wr,
  input  logic [DATA_WIDTH-1:0]          status_in
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  localparam logic [NODE_ADDR_WIDTH-1:0] MY_NODE     = NODE_ADDR_WIDTH'(NODE_ID);
  localparam logic [ADDR_WIDTH-1:0]      STATUS_ADDR = ADDR_WIDTH'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0]      ID_ADDR     = ADDR_WIDTH'(NUM_REGS + 1);
  localparam logic [DATA_WIDTH-1:0]      ID_VALUE    = DATA_WIDTH'(NODE_ID);

  logic [0:0]            state_q;
  logic                  accept;
  logic                  is_cfg;
  logic [DATA_WIDTH-1:0] cfg_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_sel;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  rd_err;

  // Handshake flags come straight from the state so that an asynchronous
  // reset in RESP withdraws rvalid immediately.
  assign req_ready = (state_q == IDLE);
  assign rvalid    = (state_q == RESP);
  assign accept    = req_valid & req_ready & (node_addr == MY_NODE);
  assign is_cfg    = (addr < STATUS_ADDR);

  // Address decode: write strobes and the read value captured at accept.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    wr_sel   = '0;
    rd_value = '0;
    rd_err   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        wr_sel[i] = accept & wen;
        rd_value  = cfg_q[i];
      end
    end
    if (addr == STATUS_ADDR) begin
      rd_value = status_in;
    end else if (addr == ID_ADDR) begin
      rd_value = ID_VALUE;
    end else if (!is_cfg) begin
      rd_err = 1'b1;
    end
  end

  // Two-state FSM: IDLE waits for a request to this node, RESP holds the
  // response beat until the router consumes it.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q <= IDLE;
    end else if (state_q == IDLE) begin
      if (accept) state_q <= RESP;
    end else if (rready) begin
      state_q <= IDLE;
    end
  end

  // Response beat is captured once at accept and held unchanged in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      wresp  <= 1'b0;
      wready <= 1'b0;
    end else if (accept) begin
      wready <= wen;
      if (wen) begin
        rdata <= '0;
        wresp <= ~is_cfg;
      end else begin
        rdata <= rd_value;
        wresp <= rd_err;
      end
    end
  end

  // Configuration bank and the one-cycle write pulse that follows each write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_wr <= '0;
      // NOTE: this bank is a set of flops driving PL logic directly, not a
      // RAM, so it is reset; a real memory array would be left unreset.
      for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= '0;
    end else begin
      cfg_wr <= wr_sel;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) cfg_q[i] <= wdata;
      end
    end
  end

  // Flatten the bank onto the cfg_out bus, register i in slice i.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_out
    assign cfg_out[g*DATA_WIDTH +: DATA_WIDTH] = cfg_q[g];
  end

endmodule

// File: tb/tb_ps_node_regs.sv
// Directed testbench for ps_node_regs (NODE_ID = 2, default widths).
module tb_ps_node_regs;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int CW = NR * DW;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    node_addr;
  logic [3:0]    addr;
  logic          wen;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic          wresp;
  logic          wready;
  logic [CW-1:0] cfg_out;
  logic [NR-1:0] cfg_wr;
  logic [DW-1:0] status_in;

  int checks = 0;
  int errors = 0;

  ps_node_regs #(
    .NODE_ID        (2),
    .NODE_ADDR_WIDTH(4),
    .DATA_WIDTH     (DW),
    .NUM_REGS       (NR),
    .ADDR_WIDTH     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .node_addr(node_addr),
    .addr     (addr),
    .wen      (wen),
    .wdata    (wdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .wresp    (wresp),
    .wready   (wready),
    .cfg_out  (cfg_out),
    .cfg_wr   (cfg_wr),
    .status_in(status_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_of(input int i);
    return cfg_out[i*DW +: DW];
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge, then withdraw it.
  task automatic send(input logic [3:0] n, input logic [3:0] a, input logic w, input logic [DW-1:0] d);
    req_valid = 1'b1;
    node_addr = n;
    addr      = a;
    wen       = w;
    wdata     = d;
    step();
    req_valid = 1'b0;
  endtask

  logic [3:0]    b2b_addr [3];
  logic [DW-1:0] b2b_data [3];

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    node_addr = '0;
    addr      = '0;
    wen       = 1'b0;
    wdata     = '0;
    rready    = 1'b0;
    status_in = '0;

    // Reset state
    step();
    step();
    check("rst_req_ready", req_ready, 1);
    check("rst_rvalid",    rvalid,    0);
    check("rst_rdata",     rdata,     0);
    check("rst_wresp",     wresp,     0);
    check("rst_wready",    wready,    0);
    check("rst_cfg_out",   cfg_out,   0);
    check("rst_cfg_wr",    cfg_wr,    0);
    rst    = 1'b0;
    rready = 1'b1;
    step();

    // Write 0xDEADBEEF to reg 2
    send(4'd2, 4'd2, 1'b1, 32'hDEAD_BEEF);
    check("wr2_rvalid",    rvalid,    1);
    check("wr2_req_ready", req_ready, 0);
    check("wr2_wready",    wready,    1);
    check("wr2_wresp",     wresp,     0);
    check("wr2_rdata",     rdata,     0);
    check("wr2_cfg_wr",    cfg_wr,    8'b0000_0100);
    check("wr2_reg2",      reg_of(2), 32'hDEAD_BEEF);
    step();
    check("wr2_done_rvalid",    rvalid,    0);
    check("wr2_done_req_ready", req_ready, 1);
    check("wr2_pulse_end",      cfg_wr,    0);

    // Read reg 2 back
    send(4'd2, 4'd2, 1'b0, 32'h0);
    check("rd2_rvalid", rvalid, 1);
    check("rd2_rdata",  rdata,  32'hDEAD_BEEF);
    check("rd2_wready", wready, 0);
    check("rd2_wresp",  wresp,  0);
    check("rd2_cfg_wr", cfg_wr, 0);
    step();

    // Write last RW register (boundary)
    send(4'd2, 4'd7, 1'b1, 32'h0777_0007);
    check("wr7_wresp",  wresp,     0);
    check("wr7_cfg_wr", cfg_wr,    8'b1000_0000);
    check("wr7_reg7",   reg_of(7), 32'h0777_0007);
    step();

    // STATUS read, sampled at accept
    status_in = 32'h0000_1234;
    send(4'd2, 4'd8, 1'b0, 32'h0);
    status_in = 32'hFFFF_FFFF;
    check("status_rdata", rdata, 32'h0000_1234);
    check("status_wresp", wresp, 0);
    step();

    // ID read
    send(4'd2, 4'd9, 1'b0, 32'h0);
    check("id_rdata",  rdata,  32'd2);
    check("id_wresp",  wresp,  0);
    check("id_wready", wready, 0);
    step();

    // Write to ID: error, no pulse
    send(4'd2, 4'd9, 1'b1, 32'h0000_AAAA);
    check("wr_id_wresp",  wresp,  1);
    check("wr_id_wready", wready, 1);
    check("wr_id_rdata",  rdata,  0);
    check("wr_id_cfg_wr", cfg_wr, 0);
    step();

    // Write to STATUS: error, no register change
    send(4'd2, 4'd8, 1'b1, 32'h5555_5555);
    check("wr_st_wresp",  wresp,   1);
    check("wr_st_cfg_wr", cfg_wr,  0);
    check("wr_st_cfg",    cfg_out, {32'h0777_0007, 128'h0, 32'hDEAD_BEEF, 64'h0});
    step();

    // Unmapped reads: first unmapped address and a higher one
    send(4'd2, 4'd10, 1'b0, 32'h0);
    check("rd10_wresp", wresp, 1);
    check("rd10_rdata", rdata, 0);
    step();
    send(4'd2, 4'd12, 1'b0, 32'h0);
    check("rd12_wresp",  wresp,  1);
    check("rd12_rdata",  rdata,  0);
    check("rd12_wready", wready, 0);
    step();

    // Request for another node is ignored
    send(4'd5, 4'd0, 1'b1, 32'd5);
    for (int i = 0; i < 10; i++) begin
      check("other_node_rvalid", rvalid, 0);
      step();
    end
    check("other_node_reg0",   reg_of(0), 0);
    check("other_node_cfg_wr", cfg_wr,    0);

    // Hold rready low for 7 cycles with a second request pending
    rready = 1'b0;
    send(4'd2, 4'd2, 1'b0, 32'h0);
    req_valid = 1'b1;
    node_addr = 4'd2;
    addr      = 4'd7;
    wen       = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("stall_rvalid",    rvalid,    1);
      check("stall_rdata",     rdata,     32'hDEAD_BEEF);
      check("stall_req_ready", req_ready, 0);
      step();
    end
    rready = 1'b1;
    check("stall_last_rvalid", rvalid, 1);
    step();
    check("stall_hs_rvalid",    rvalid,    0);
    check("stall_hs_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("second_rvalid", rvalid, 1);
    check("second_rdata",  rdata,  32'h0777_0007);
    step();

    // Back-to-back requests, rready high: one response per 2 cycles
    b2b_addr[0] = 4'd2; b2b_data[0] = 32'hDEAD_BEEF;
    b2b_addr[1] = 4'd7; b2b_data[1] = 32'h0777_0007;
    b2b_addr[2] = 4'd9; b2b_data[2] = 32'd2;
    req_valid = 1'b1;
    node_addr = 4'd2;
    wen       = 1'b0;
    for (int k = 0; k < 3; k++) begin
      addr = b2b_addr[k];
      step();
      check("b2b_rvalid", rvalid, 1);
      check("b2b_rdata",  rdata,  b2b_data[k]);
      if (k == 2) req_valid = 1'b0;
      step();
      check("b2b_gap_rvalid",    rvalid,    0);
      check("b2b_gap_req_ready", req_ready, 1);
    end

    // Reset asserted while in RESP with a cfg_wr pulse in flight
    rready = 1'b0;
    send(4'd2, 4'd3, 1'b1, 32'h0000_0033);
    check("pre_rst_rvalid", rvalid,    1);
    check("pre_rst_cfg_wr", cfg_wr,    8'b0000_1000);
    check("pre_rst_reg3",   reg_of(3), 32'h0000_0033);
    rst = 1'b1;
    #1;
    check("async_rst_rvalid",    rvalid,    0);
    check("async_rst_req_ready", req_ready, 1);
    check("async_rst_cfg_wr",    cfg_wr,    0);
    check("async_rst_cfg_out",   cfg_out,   0);
    step();
    rst    = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_rvalid", rvalid, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
